// File: rtl/free_list_pkg.sv
// Shared widths, pointer type and pointer arithmetic for the rename free list.
package free_list_pkg;
  localparam int FL_ALLOC_WIDTH  = 4;
  localparam int FL_NUM_ARCH     = 32;
  localparam int FL_NUM_PHYS     = 64;
  localparam int FL_CKPT_COUNT   = 8;
  localparam int FL_DEPTH        = FL_NUM_PHYS - FL_NUM_ARCH;
  localparam int FL_PREG_BITS    = $clog2(FL_NUM_PHYS);
  localparam int FL_CKPT_BITS    = $clog2(FL_CKPT_COUNT);
  localparam int FL_IDX_BITS     = $clog2(FL_DEPTH);
  localparam int FL_CNT_BITS     = $clog2(FL_DEPTH) + 1;
  localparam int FL_LANE_BITS    = $clog2(FL_ALLOC_WIDTH) + 1;

  typedef struct packed {
    logic                   wrap;
    logic [FL_IDX_BITS-1:0] idx;
  } ptr_t;

  // Index wraps modulo DEPTH (not necessarily a power of two); wrap bit toggles on wrap.
  function automatic ptr_t ptr_add(ptr_t p, logic [FL_LANE_BITS-1:0] n);
    ptr_t                 r;
    logic [FL_IDX_BITS:0] s;
    s = {1'b0, p.idx} + (FL_IDX_BITS+1)'(n);
    r = p;
    if (s >= (FL_IDX_BITS+1)'(FL_DEPTH)) begin
      r.idx  = FL_IDX_BITS'(s - (FL_IDX_BITS+1)'(FL_DEPTH));
      r.wrap = ~p.wrap;
    end else begin
      r.idx = s[FL_IDX_BITS-1:0];
    end
    return r;
  endfunction

  function automatic logic [FL_CNT_BITS-1:0] ptr_diff(ptr_t t, ptr_t h);
    if (t.wrap == h.wrap) return FL_CNT_BITS'(t.idx) - FL_CNT_BITS'(h.idx);
    return FL_CNT_BITS'(FL_DEPTH) + FL_CNT_BITS'(t.idx) - FL_CNT_BITS'(h.idx);
  endfunction
endpackage

// File: rtl/free_list_if.sv
// Allocation / free / checkpoint bundle of the free list.
interface free_list_if import free_list_pkg::*; ;
  logic [FL_ALLOC_WIDTH-1:0]                   alloc_req;
  logic [FL_ALLOC_WIDTH-1:0][FL_PREG_BITS-1:0] alloc_preg;
  logic [FL_ALLOC_WIDTH-1:0]                   alloc_valid;
  logic [FL_ALLOC_WIDTH-1:0]                   free_req;
  logic [FL_ALLOC_WIDTH-1:0][FL_PREG_BITS-1:0] free_preg;
  logic                                        checkpoint_save;
  logic [FL_CKPT_BITS-1:0]                     checkpoint_slot;
  logic                                        checkpoint_restore;
  logic [FL_CKPT_BITS-1:0]                     restore_slot;
  logic [FL_CNT_BITS-1:0]                      free_count;
  logic                                        err;

  modport master (
    output alloc_req, free_req, free_preg, checkpoint_save, checkpoint_slot,
           checkpoint_restore, restore_slot,
    input  alloc_preg, alloc_valid, free_count, err
  );
  modport slave (
    input  alloc_req, free_req, free_preg, checkpoint_save, checkpoint_slot,
           checkpoint_restore, restore_slot,
    output alloc_preg, alloc_valid, free_count, err
  );
endinterface

// File: rtl/fl_prefix_count.sv
// Per-lane count of set mask bits in lower lanes (compaction offset) plus total.
module fl_prefix_count #(
  parameter int W  = 4,
  parameter int CW = $clog2(W) + 1
) (
  input  logic [W-1:0]         mask,
  output logic [W-1:0][CW-1:0] prefix,
  output logic [CW-1:0]        total
);
  always_comb begin
    total = '0;
    for (int i = 0; i < W; i++) begin
      prefix[i] = total;
      total     = total + CW'(mask[i]);
    end
  end
endmodule

// File: rtl/free_list.sv
// Physical-register free list with multi-lane alloc/free and head checkpoints.
// Optional FREELIST_DUP_CHECK_EN keeps a free bitmap that drops double frees.
module free_list import free_list_pkg::*; #(
  parameter int ALLOC_WIDTH      = FL_ALLOC_WIDTH,
  parameter int NUM_ARCH_REGS    = FL_NUM_ARCH,
  parameter int NUM_PHYS_REGS    = FL_NUM_PHYS,
  parameter int CHECKPOINT_COUNT = FL_CKPT_COUNT
) (
  input logic        clk,
  input logic        rst,
  free_list_if.slave bus
);
  localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;

  logic [DEPTH-1:0][FL_PREG_BITS-1:0] q;
  ptr_t                               head, tail, commit_head;
  ptr_t                               head_pop, head_nxt, tail_nxt, commit_nxt;
  ptr_t                               ckpt_head [CHECKPOINT_COUNT];
  logic [CHECKPOINT_COUNT-1:0]        ckpt_vld;
  logic                               err_q, err_set;
  logic [FL_CNT_BITS-1:0]             count, space;

  logic [ALLOC_WIDTH-1:0][FL_LANE_BITS-1:0]  a_pre, f_pre;
  logic [FL_LANE_BITS-1:0]                   a_tot, f_tot, pop_n, push_n;
  logic [ALLOC_WIDTH-1:0]                    a_vld, dup, f_cand, push;
  logic [ALLOC_WIDTH-1:0][FL_PREG_BITS-1:0]  a_preg;
  logic                                      all_ok;
  ptr_t                                      a_ptr;

  assign count = ptr_diff(tail, head);

  fl_prefix_count #(.W(ALLOC_WIDTH), .CW(FL_LANE_BITS)) u_alloc_pc (
    .mask(bus.alloc_req), .prefix(a_pre), .total(a_tot)
  );
  fl_prefix_count #(.W(ALLOC_WIDTH), .CW(FL_LANE_BITS)) u_free_pc (
    .mask(f_cand), .prefix(f_pre), .total(f_tot)
  );

  always_comb begin
    a_ptr = head;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      a_ptr     = ptr_add(head, a_pre[i]);
      a_preg[i] = q[a_ptr.idx];
      a_vld[i]  = bus.alloc_req[i] && (FL_CNT_BITS'(a_pre[i]) < count);
    end
    all_ok = ((bus.alloc_req & ~a_vld) == '0);
    pop_n  = (all_ok && !bus.checkpoint_restore) ? a_tot : '0;
  end

  assign bus.alloc_preg  = a_preg;
  assign bus.alloc_valid = a_vld;
  assign bus.free_count  = count;
  assign bus.err         = err_q;

  // Restore suppresses the pop; otherwise head advances past this cycle's grants.
  always_comb begin
    head_pop = ptr_add(head, pop_n);
    head_nxt = head_pop;
    if (bus.checkpoint_restore)
      head_nxt = ckpt_vld[bus.restore_slot] ? ckpt_head[bus.restore_slot] : commit_head;
  end

`ifdef FREELIST_DUP_CHECK_EN
  logic [NUM_PHYS_REGS-1:0] free_map, map_nxt;

  always_comb begin
    dup = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      dup[i] = free_map[bus.free_preg[i]];
      for (int j = 0; j < i; j++)
        if (bus.free_req[j] && bus.free_preg[j] == bus.free_preg[i]) dup[i] = 1'b1;
    end
  end

  // A rollback re-frees everything between the new head and tail, so rebuild from the queue.
  always_comb begin
    int off;
    map_nxt = free_map;
    off     = 0;
    if (bus.checkpoint_restore) begin
      map_nxt = '0;
      for (int k = 0; k < DEPTH; k++) begin
        off = (k >= int'(head_nxt.idx)) ? k - int'(head_nxt.idx) : k + DEPTH - int'(head_nxt.idx);
        if (off < int'(ptr_diff(tail, head_nxt))) map_nxt[q[k]] = 1'b1;
      end
    end else if (pop_n != '0) begin
      for (int i = 0; i < ALLOC_WIDTH; i++)
        if (bus.alloc_req[i]) map_nxt[a_preg[i]] = 1'b0;
    end
    for (int i = 0; i < ALLOC_WIDTH; i++)
      if (push[i]) map_nxt[bus.free_preg[i]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PHYS_REGS; p++) free_map[p] <= (p >= NUM_ARCH_REGS);
    end else begin
      free_map <= map_nxt;
    end
  end
`else
  assign dup = '0;
`endif

  always_comb begin
    for (int i = 0; i < ALLOC_WIDTH; i++)
      f_cand[i] = bus.free_req[i] && (bus.free_preg[i] != '0) && !dup[i];
    space = FL_CNT_BITS'(DEPTH) - ptr_diff(tail, head_nxt);
    for (int i = 0; i < ALLOC_WIDTH; i++)
      push[i] = f_cand[i] && (FL_CNT_BITS'(f_pre[i]) < space);
    push_n = (FL_CNT_BITS'(f_tot) <= space) ? f_tot : FL_LANE_BITS'(space);
    err_set = 1'b0;
    for (int i = 0; i < ALLOC_WIDTH; i++)
      if ((f_cand[i] && !push[i]) || (bus.free_req[i] && bus.free_preg[i] != '0 && dup[i]))
        err_set = 1'b1;
    tail_nxt   = ptr_add(tail, push_n);
    commit_nxt = ptr_add(commit_head, push_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) q[k] <= FL_PREG_BITS'(NUM_ARCH_REGS + k);
      head        <= '0;
      commit_head <= '0;
      tail        <= '{wrap: 1'b1, idx: '0};
      err_q       <= 1'b0;
      ckpt_vld    <= '0;
    end else begin
      head        <= head_nxt;
      tail        <= tail_nxt;
      commit_head <= commit_nxt;
      err_q       <= err_q | err_set;
      for (int i = 0; i < ALLOC_WIDTH; i++)
        if (push[i]) q[ptr_add(tail, f_pre[i]).idx] <= bus.free_preg[i];
      if (bus.checkpoint_restore) begin
        ckpt_vld <= ckpt_vld & (CHECKPOINT_COUNT'(1) << bus.restore_slot);
      end else if (bus.checkpoint_save) begin
        ckpt_vld[bus.checkpoint_slot]  <= 1'b1;
        ckpt_head[bus.checkpoint_slot] <= head_pop;
      end
    end
  end
endmodule
